// File: rtl/aes_fsm_pkg.sv
// Shared constants for the AES-128 decryptor control FSM: widths, state encoding, key-expansion codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_fsm_pkg;

    localparam int KEY_W = 128;
    localparam int NR    = 10;
    localparam int RND_W = 4;

    localparam logic [RND_W-1:0] LAST_RND = 4'(NR);

    // State encoding is fixed so the register value stays compatible with existing debug tooling
    localparam logic [2:0] ST_IDLE     = 3'b000;
    localparam logic [2:0] ST_KEY_LOAD = 3'b001;
    localparam logic [2:0] ST_KEY_EXP  = 3'b010;
    localparam logic [2:0] ST_DEC_LOAD = 3'b011;
    localparam logic [2:0] ST_DEC      = 3'b100;
    localparam logic [2:0] ST_DONE     = 3'b101;

    // Key-expansion command codes
    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_LOAD = 2'b01;
    localparam logic [1:0] CTRL_FWD  = 2'b10;
    localparam logic [1:0] CTRL_INV  = 2'b11;

endpackage

// File: rtl/fsm_key_cache.sv
// Holds the requested cipher key, the cached last round key K10 and the hit comparator.
// Latency: registers update one clock after load_key/capture; hit is combinational on key_in.
// Backpressure: none; FSM_KEY_CACHE_EN enables the cache, otherwise hit is always 0.
module fsm_key_cache
    import aes_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_key,
    input  logic [KEY_W-1:0] key_in,
    input  logic             capture,
    input  logic [KEY_W-1:0] round_key,
    output logic [KEY_W-1:0] key_reg,
    output logic [KEY_W-1:0] last_key,
    output logic             hit
);

    logic cache_valid;

    // Latch the requested key whenever a start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg <= '0;
        end else if (load_key) begin
            key_reg <= key_in;
        end
    end

    // Remember K10 from the first inverse-schedule cycle for later requests with the same key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key <= '0;
        end else if (capture) begin
            last_key <= round_key;
        end
    end

`ifdef FSM_KEY_CACHE_EN
    // Cache becomes valid once a K10 has been captured; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
        end else if (capture) begin
            cache_valid <= 1'b1;
        end
    end
`else
    assign cache_valid = 1'b0;
`endif

    // Compare against the previously latched key, before this request overwrites it
    assign hit = cache_valid & (key_in == key_reg);

endmodule

// File: rtl/fsm_controller.sv
// Control FSM for the iterative AES-128 decryptor: forward key schedule to K10, then inverse rounds.
// Latency: vaild_out 23 cycles after start on a miss, 13 on a cache hit (FSM_KEY_CACHE_EN defined).
// Backpressure: none; vaild_in is only accepted in IDLE, starts arriving while busy are dropped.
module fsm_controller
    import aes_fsm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vaild_in,
    input  logic [KEY_W-1:0] key_in,
    output logic             vaild_out,
    output logic [RND_W-1:0] round_count_to_keyExp,
    output logic [KEY_W-1:0] KeyOut_KeyExpLoad,
    input  logic [KEY_W-1:0] KeyExp_RoundKey,
    output logic [1:0]       KeyExp_control,
    output logic             Decryptor_en
);

    logic [2:0]       current_state;
    logic [RND_W-1:0] rnd;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] last_key;
    logic             hit;
    logic             load_key;
    logic             capture;

    assign load_key = (current_state == ST_IDLE) & vaild_in;
    assign capture  = (current_state == ST_DEC) & (rnd == LAST_RND);

    fsm_key_cache u_key_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_key  (load_key),
        .key_in    (key_in),
        .capture   (capture),
        .round_key (KeyExp_RoundKey),
        .key_reg   (key_reg),
        .last_key  (last_key),
        .hit       (hit)
    );

    // State and round counter sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= ST_IDLE;
            rnd           <= '0;
        end else begin
            case (current_state)
                ST_IDLE: begin
                    if (vaild_in) begin
                        if (hit) begin
                            current_state <= ST_DEC_LOAD;
                            rnd           <= LAST_RND;
                        end else begin
                            current_state <= ST_KEY_LOAD;
                            rnd           <= '0;
                        end
                    end
                end
                ST_KEY_LOAD: begin
                    current_state <= ST_KEY_EXP;
                    rnd           <= 4'd1;
                end
                ST_KEY_EXP: begin
                    if (rnd == LAST_RND) begin
                        current_state <= ST_DEC;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ST_DEC_LOAD: begin
                    current_state <= ST_DEC;
                    rnd           <= LAST_RND;
                end
                ST_DEC: begin
                    if (rnd == '0) begin
                        current_state <= ST_DONE;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                ST_DONE: begin
                    current_state <= ST_IDLE;
                    rnd           <= '0;
                end
                default: begin
                    current_state <= ST_IDLE;
                    rnd           <= '0;
                end
            endcase
        end
    end

    // Moore output decode; anything not driven in a state stays 0
    always_comb begin
        vaild_out             = 1'b0;
        round_count_to_keyExp = '0;
        KeyOut_KeyExpLoad     = '0;
        KeyExp_control        = CTRL_HOLD;
        Decryptor_en          = 1'b0;
        case (current_state)
            ST_KEY_LOAD: begin
                KeyExp_control        = CTRL_LOAD;
                KeyOut_KeyExpLoad     = key_reg;
                round_count_to_keyExp = rnd;
            end
            ST_KEY_EXP: begin
                KeyExp_control        = CTRL_FWD;
                round_count_to_keyExp = rnd;
            end
            ST_DEC_LOAD: begin
                KeyExp_control        = CTRL_LOAD;
                KeyOut_KeyExpLoad     = last_key;
                round_count_to_keyExp = rnd;
            end
            ST_DEC: begin
                Decryptor_en          = 1'b1;
                round_count_to_keyExp = rnd;
                // Round 0 uses K0 directly, so the schedule holds instead of stepping past it
                KeyExp_control        = (rnd != '0) ? CTRL_INV : CTRL_HOLD;
            end
            ST_DONE: begin
                vaild_out = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_controller.sv
// Scoreboard bench for fsm_controller: stimulus pushes per-cycle expected outputs, a monitor pops them.
// Latency: expectations carry absolute cycle numbers, so sequence timing is checked too.
// Backpressure: n/a; expectations follow FSM_KEY_CACHE_EN the same way the design does.
module tb_fsm_controller;

    logic         clk;
    logic         rst_n;
    logic         vaild_in;
    logic [127:0] key_in;
    logic         vaild_out;
    logic [3:0]   round_count_to_keyExp;
    logic [127:0] KeyOut_KeyExpLoad;
    logic [127:0] KeyExp_RoundKey;
    logic [1:0]   KeyExp_control;
    logic         Decryptor_en;

    logic [127:0] rk_base;

    typedef struct {
        int           cyc;
        logic [1:0]   ctrl;
        logic [3:0]   rnd;
        logic         en;
        logic [127:0] kout;
        logic         vo;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   failures;

    // Bench-side model of the key cache
    logic         cv_m;
    logic [127:0] kreg_m;
    logic [127:0] cached_k10;

    localparam logic [127:0] KEY_A = 128'hAABBCCDDEEFF00112233445566778899;
    localparam logic [127:0] KEY_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] KEY_C = 128'h11111111222222223333333344444444;
    localparam logic [127:0] RK1   = 128'hDEADBEEF00000000CAFEF00D12345670;
    localparam logic [127:0] RK2   = 128'h0123456789ABCDEF0011223344556600;

    // Key-expansion stand-in: round key depends on the round index it is asked for
    assign KeyExp_RoundKey = rk_base ^ {124'd0, round_count_to_keyExp};

    fsm_controller dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .vaild_in              (vaild_in),
        .key_in                (key_in),
        .vaild_out             (vaild_out),
        .round_count_to_keyExp (round_count_to_keyExp),
        .KeyOut_KeyExpLoad     (KeyOut_KeyExpLoad),
        .KeyExp_RoundKey       (KeyExp_RoundKey),
        .KeyExp_control        (KeyExp_control),
        .Decryptor_en          (Decryptor_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic push_exp(input int c, input logic [1:0] ctrl, input logic [3:0] r,
                            input logic en, input logic [127:0] k, input logic vo);
        exp_t e;
        e.cyc = c; e.ctrl = ctrl; e.rnd = r; e.en = en; e.kout = k; e.vo = vo;
        q.push_back(e);
    endtask

    task automatic push_dec(input int t);
        for (int j = 0; j <= 10; j++) begin
            logic [3:0] r;
            r = 4'(10 - j);
            push_exp(t + j, (r != 4'd0) ? 2'b11 : 2'b00, r, 1'b1, 128'd0, 1'b0);
        end
        push_exp(t + 11, 2'b00, 4'd0, 1'b0, 128'd0, 1'b1);
        cv_m       = 1'b1;
        cached_k10 = rk_base ^ 128'd10;
    endtask

    task automatic start(input logic [127:0] key);
        logic hit;
        int   t0;
        @(negedge clk);
        t0  = cyc;
        hit = 1'b0;
`ifdef FSM_KEY_CACHE_EN
        hit = cv_m && (key == kreg_m);
`endif
        kreg_m   = key;
        vaild_in = 1'b1;
        key_in   = key;
        if (hit) begin
            push_exp(t0 + 1, 2'b01, 4'd10, 1'b0, cached_k10, 1'b0);
            push_dec(t0 + 2);
        end else begin
            push_exp(t0 + 1, 2'b01, 4'd0, 1'b0, key, 1'b0);
            for (int i = 1; i <= 10; i++) begin
                push_exp(t0 + 1 + i, 2'b10, 4'(i), 1'b0, 128'd0, 1'b0);
            end
            push_dec(t0 + 12);
        end
        @(negedge clk);
        vaild_in = 1'b0;
        key_in   = 128'd0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("done_timeout_pending", 128'(q.size()), 128'd0);
        q.delete();
        @(negedge clk);
    endtask

    // Monitor: pops an expectation whenever the DUT drives anything or one falls due
    always @(negedge clk) begin
        logic active;
        exp_t e;
        if (rst_n) begin
            active = (KeyExp_control != 2'b00) || Decryptor_en || vaild_out ||
                     (KeyOut_KeyExpLoad != 128'd0) || (round_count_to_keyExp != 4'd0);
            if (q.size() > 0 && (active || q[0].cyc <= cyc)) begin
                e = q.pop_front();
                chk("cycle", 128'(cyc), 128'(e.cyc));
                chk("ctrl", 128'(KeyExp_control), 128'(e.ctrl));
                chk("rnd", 128'(round_count_to_keyExp), 128'(e.rnd));
                chk("dec_en", 128'(Decryptor_en), 128'(e.en));
                chk("keyout", KeyOut_KeyExpLoad, e.kout);
                chk("vaild_out", 128'(vaild_out), 128'(e.vo));
            end else if (active) begin
                chk("unexpected_output", 128'(active), 128'd0);
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, 128'(dut.current_state), 128'd0);
        chk({tag, "_vaild_out"}, 128'(vaild_out), 128'd0);
        chk({tag, "_ctrl"}, 128'(KeyExp_control), 128'd0);
        chk({tag, "_rnd"}, 128'(round_count_to_keyExp), 128'd0);
        chk({tag, "_keyout"}, KeyOut_KeyExpLoad, 128'd0);
        chk({tag, "_dec_en"}, 128'(Decryptor_en), 128'd0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cv_m       = 1'b0;
        kreg_m     = 128'd0;
        cached_k10 = 128'd0;
        rst_n      = 1'b0;
        vaild_in   = 1'b0;
        key_in     = 128'd0;
        rk_base    = RK1;

        // Reset state, then release with no request
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("post_reset");

        // First request is always a miss
        start(KEY_A);
        wait_done();

        // Same key: hit must replay the K10 captured during the first run, not the current one
        rk_base = RK2;
        start(KEY_A);
        wait_done();

        // Different key forces the full schedule
        start(KEY_B);
        wait_done();

        // Starts while busy are dropped and must not disturb the cached key
        start(KEY_A);
        repeat (4) @(negedge clk);
        vaild_in = 1'b1;
        key_in   = KEY_C;
        @(negedge clk);
        vaild_in = 1'b0;
        repeat (9) @(negedge clk);
        vaild_in = 1'b1;
        key_in   = KEY_C;
        @(negedge clk);
        vaild_in = 1'b0;
        key_in   = 128'd0;
        wait_done();

        // Reset in the middle of the inverse rounds
        start(KEY_A);
        for (int i = 0; i < 40; i++) begin
            if (Decryptor_en) break;
            @(negedge clk);
        end
        chk("reach_dec", 128'(Decryptor_en), 128'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        cv_m   = 1'b0;
        kreg_m = 128'd0;
        #1;
        chk_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Cache was dropped by reset: same key takes the miss path
        start(KEY_A);
        wait_done();

        repeat (3) @(negedge clk);
        chk("queue_empty_at_end", 128'(q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
